regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single write port of the 32-entry register file between several writeback sources (ALU, load unit, multiplier) using round-robin arbitration with per-source valid/ready handshakes. Drives the register-file write port from registers and keeps a busy scoreboard of registers with an outstanding write. The issue stage reads that scoreboard for RAW hazard stalls. Sits between the execution units and the register file's `wr_en`/`wr_addr`/`wr_data` inputs.

## Interface
- WIDTH, `WORD (32): data width of one register.
- ADDR_SPACE, `REG_ADDRESS_SPACE (5): register address width.
- REG_AMOUNT, 32: number of registers, and width of the scoreboard.
- NUM_REQ, 3: number of writeback requesters; legal range 2..8.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i holds a write in bit i.
- req_addr  in  NUM_REQ*ADDR_SPACE  destination of requester i, in slice [i*ADDR_SPACE +: ADDR_SPACE].
- req_data  in  NUM_REQ*WIDTH  write data of requester i, in slice [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; the grant to requester i.
- issue_en  in  1  the issue stage dispatched an instruction that writes issue_addr.
- issue_addr  in  ADDR_SPACE  destination register of the dispatched instruction.
- busy  out  REG_AMOUNT  bit r set means register r has a write outstanding.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_SPACE  register-file write address.
- wr_data  out  WIDTH  register-file write data.

## Operation
**Arbitration**
- Round-robin pointer `ptr` ranges 0..NUM_REQ-1 and resets to 0.
- Each cycle, the first requester with req_valid set is granted, searching ptr, ptr+1, … modulo NUM_REQ.
- req_ready is asserted only for the granted requester. With no valid requester, req_ready is all zero.
- A transfer happens when req_valid[i] and req_ready[i] are both high.
- After a transfer by requester i, ptr becomes (i+1) mod NUM_REQ. With no transfer, ptr holds.
- A requester must hold valid, addr and data stable until its transfer. A valid requester is served within NUM_REQ cycles.

**Write port**
- On a transfer with addr ≠ 0: at the next edge, wr_en=1, wr_addr=addr and wr_data=data are registered.
- On a transfer with addr = 0: the transfer is consumed (ready is given), but wr_en=0 next cycle and busy is not touched.
- With no transfer, wr_en=0 next cycle. wr_addr and wr_data hold their last values.

**Scoreboard**
- issue_en with issue_addr ≠ 0 sets busy[issue_addr] at the next edge.
- A transfer with addr ≠ 0 clears busy[addr] at the same edge that registers wr_en.
- If set and clear hit the same register in the same cycle, set wins: the new writer is outstanding.
- busy[0] is constant 0.
- Only one outstanding writer per register is supported. The issue stage stalls on busy; this block does not check for double issue.

**Reset**
- Asserting rst_n low at any time, including mid-transfer, clears the following immediately:
  - ptr=0.
  - busy=0.
  - wr_en=0, wr_addr=0, wr_data=0.
- Any in-flight write is dropped.
- req_ready is combinational and therefore reflects ptr=0 during reset. Sources must not treat it as a transfer while rst_n is low.

## Timing
- req_ready is combinational from req_valid and ptr only. It never depends on req_addr, req_data or issue_*.
- Latency from transfer to register-file write is 1 cycle: wr_* is visible in the cycle after the transfer and written at the following edge.
- The data is readable through the register file's combinational read in the cycle after wr_en.
- busy clears one cycle after the transfer cycle. This is the same cycle wr_en is high.
- The issue stage may read the register in the cycle after busy falls.
- Throughput: one write per cycle, sustained.
- Reset values of every output:
  - req_ready follows arbitration with ptr=0.
  - busy=0.
  - wr_en=0, wr_addr=0, wr_data=0.

## Test plan
- **Single requester.** Stimulus: req_valid=3'b010, addr=5, data=0xDEADBEEF. Required response: req_ready=3'b010 the same cycle; the next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; then wr_en=0 once valid drops.
- **Round-robin fairness.** Stimulus: all three valid and held for 6 cycles, each re-presenting a new write after its transfer. Required response: grant sequence 0,1,2,0,1,2; wr_en=1 every cycle from cycle 1.
- **Scoreboard.** Stimulus: issue_en with addr 7. Required response: busy[7]=1 next cycle. Stimulus: requester 2 writes addr 7. Required response: busy[7]=0 in the same cycle wr_en=1. Stimulus: set and clear of addr 9 in one cycle. Required response: busy[9] stays 1.
- **Register zero.** Stimulus: requester 0 writes addr 0, data 0xFFFFFFFF. Required response: req_ready[0]=1, wr_en=0 next cycle, busy unchanged. Stimulus: issue_en with addr 0. Required response: busy[0]=0.
- **Backpressure stability.** Stimulus: requester 1 held valid while requesters 0 and 2 stream writes. Required response: requester 1 granted within 3 cycles; its addr and data appear unmodified on wr_*.
- **Async reset mid-burst.** Stimulus: rst_n low between edges while wr_en=1 and busy=0x00000880. Required response: wr_en, wr_addr, wr_data and busy all 0 immediately; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port
// between writeback sources, plus a busy scoreboard for RAW hazard stalls.
module regfile_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_SPACE = 5,
  parameter int REG_AMOUNT = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_SPACE-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          issue_en,
  input  logic [ADDR_SPACE-1:0]         issue_addr,
  output logic [REG_AMOUNT-1:0]         busy,
  output logic                          wr_en,
  output logic [ADDR_SPACE-1:0]         wr_addr,
  output logic [WIDTH-1:0]              wr_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [REG_AMOUNT-1:0] R0_MASK =
    {{(REG_AMOUNT-1){1'b1}}, 1'b0};

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t                  ptr;
  ptr_t                  ptr_nxt;
  ptr_t                  gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  xfer;
  logic                  wr_go;
  int                    idx;
  logic [ADDR_SPACE-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;
  logic [REG_AMOUNT-1:0] set_mask;
  logic [REG_AMOUNT-1:0] clr_mask;
  logic [REG_AMOUNT-1:0] busy_nxt;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!xfer && req_valid[idx]) begin
        xfer     = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ptr_t'(idx);
      end
    end
  end

  assign req_ready = gnt;

  assign sel_addr =
    req_addr[int'(gnt_idx)*ADDR_SPACE +: ADDR_SPACE];
  assign sel_data =
    req_data[int'(gnt_idx)*WIDTH +: WIDTH];

  assign wr_go = xfer && (sel_addr != '0);

  always_comb begin
    ptr_nxt = ptr;
    if (xfer) begin
      if (gnt_idx == ptr_t'(NUM_REQ-1))
        ptr_nxt = '0;
      else
        ptr_nxt = gnt_idx + 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle reissue stays busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_en && issue_addr != '0)
      set_mask = REG_AMOUNT'(1) << issue_addr;
    if (wr_go)
      clr_mask = REG_AMOUNT'(1) << sel_addr;
    busy_nxt = ((busy & ~clr_mask) | set_mask) & R0_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      busy    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule
